// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared codes for the multicycle MIPS control unit
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH       = 5'd0,
    S_DECODE      = 5'd1,
    S_COMPUTE_MEM = 5'd2,
    S_MEM_READ    = 5'd3,
    S_MEM_WBACK   = 5'd4,
    S_MEM_WRITE   = 5'd5,
    S_R_ALU       = 5'd6,
    S_R_WREG      = 5'd7,
    S_BEQ         = 5'd8,
    S_JUMP        = 5'd9,
    S_BNE         = 5'd10,
    S_I_ALU       = 5'd11,
    S_I_WREG      = 5'd12,
    S_LUI         = 5'd13,
    S_JR          = 5'd14,
    S_JAL         = 5'd15,
    S_JALR        = 5'd16,
    S_SRL         = 5'd17,
    S_TRAP        = 5'd18
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b011;

  // ALU_OP selects how the ALU operation is derived: fixed add/sub, from func, or from op.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_IMM  = 2'b11;

  localparam logic [2:0] PCS_ALU    = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_RS     = 3'b011;
  localparam logic [2:0] PCS_EXC    = 3'b100;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// rtl/multicycle_ctrl_alu_op_decode.sv - combinational ALU operation decode
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_operation
);

  always_comb begin
    o_alu_operation = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_operation = ALU_SUB;
      ALUOP_FUNC: begin
        case (i_func)
          FN_ADD:  o_alu_operation = ALU_ADD;
          FN_SUB:  o_alu_operation = ALU_SUB;
          FN_AND:  o_alu_operation = ALU_AND;
          FN_OR:   o_alu_operation = ALU_OR;
          FN_SLT:  o_alu_operation = ALU_SLT;
          FN_SRL:  o_alu_operation = ALU_SRL;
          FN_NOR:  o_alu_operation = ALU_NOR;
          FN_XOR:  o_alu_operation = ALU_XOR;
          default: o_alu_operation = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        case (i_op)
          OP_ANDI: o_alu_operation = ALU_AND;
          OP_ORI:  o_alu_operation = ALU_OR;
          OP_SLTI: o_alu_operation = ALU_SLT;
          OP_XORI: o_alu_operation = ALU_XOR;
          default: o_alu_operation = ALU_ADD;
        endcase
      end
      default: o_alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM with memory stalls, watchdog and traps
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_WAIT = 1'b1,
  parameter bit          TRAP_EN  = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        Shift,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic [1:0]  cause,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        CPU_MIO,
  output logic [4:0]  state_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause, w_cause_next;
  logic [1:0]    w_alu_op;
  logic [2:0]    w_alu_operation;
  logic          w_mem_wait, w_tmo, w_ill, w_fetch_done, w_unused;

  wire [5:0] w_op   = Inst_in[31:26];
  wire [5:0] w_func = Inst_in[5:0];

  assign w_unused     = ^{zero, Inst_in[25:6]};
  assign w_mem_wait   = MEM_WAIT && !MIO_ready;
  // The last tolerated stall cycle: counter has seen TIMEOUT-1 stalls already.
  assign w_tmo        = TRAP_EN && (r_cnt == LAST);
  assign w_fetch_done = !w_mem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cause <= CAUSE_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (is_mem_state(r_state) && (w_next == r_state))
        r_cnt <= (r_cnt == LAST) ? r_cnt : r_cnt + CW'(1);
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_cause_next = CAUSE_NONE;
    w_ill        = 1'b0;
    case (r_state)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (w_mem_wait) begin
          if (w_tmo) begin
            w_next       = S_TRAP;
            w_cause_next = CAUSE_TMO;
          end else begin
            w_next = r_state;
          end
        end else begin
          case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_MEM_READ: w_next = S_MEM_WBACK;
            default:    w_next = S_FETCH;
          endcase
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_RTYPE: begin
            case (w_func)
              FN_ADD, FN_SUB, FN_AND, FN_OR,
              FN_XOR, FN_NOR, FN_SLT: w_next = S_R_ALU;
              FN_SRL:                 w_next = S_SRL;
              FN_JR:                  w_next = S_JR;
              FN_JALR:                w_next = S_JALR;
              default:                w_ill  = 1'b1;
            endcase
          end
          OP_LW, OP_SW:                     w_next = S_COMPUTE_MEM;
          OP_BEQ:                           w_next = S_BEQ;
          OP_BNE:                           w_next = S_BNE;
          OP_J:                             w_next = S_JUMP;
          OP_JAL:                           w_next = S_JAL;
          OP_LUI:                           w_next = S_LUI;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI:                  w_next = S_I_ALU;
          default:                          w_ill  = 1'b1;
        endcase
        if (w_ill) begin
          w_next       = TRAP_EN ? S_TRAP : S_FETCH;
          w_cause_next = TRAP_EN ? CAUSE_ILL : CAUSE_NONE;
        end
      end
      S_COMPUTE_MEM: w_next = (w_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_R_ALU: begin
        w_next = S_R_WREG;
        if (TRAP_EN && overflow && ((w_func == FN_ADD) || (w_func == FN_SUB))) begin
          w_next       = S_TRAP;
          w_cause_next = CAUSE_OVF;
        end
      end
      S_I_ALU: begin
        w_next = S_I_WREG;
        if (TRAP_EN && overflow && (w_op == OP_ADDI)) begin
          w_next       = S_TRAP;
          w_cause_next = CAUSE_OVF;
        end
      end
      S_SRL:   w_next = S_R_WREG;
      S_JAL:   w_next = S_JUMP;
      S_JALR:  w_next = S_JR;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0;
    Branch = 1'b0; Shift = 1'b0; EPCWrite = 1'b0; CauseWrite = 1'b0;
    RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcB = 2'b00;
    PCSource = PCS_ALU; w_alu_op = ALUOP_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01;
          IRWrite = w_fetch_done; PCWrite = w_fetch_done;
        end
        S_DECODE:      ALUSrcB = 2'b11;
        S_COMPUTE_MEM: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_MEM_READ:    begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEM_WBACK:   begin RegWrite = 1'b1; MemtoReg = 2'b01; end
        S_MEM_WRITE:   begin MemWrite = 1'b1; IorD = 1'b1; end
        S_R_ALU:       begin ALUSrcA = 1'b1; w_alu_op = ALUOP_FUNC; end
        S_R_WREG:      begin RegWrite = 1'b1; RegDst = 2'b01; end
        S_BEQ, S_BNE: begin
          ALUSrcA = 1'b1; w_alu_op = ALUOP_SUB; PCWriteCond = 1'b1;
          PCSource = PCS_ALUOUT; Branch = (r_state == S_BEQ);
        end
        S_JUMP:        begin PCWrite = 1'b1; PCSource = PCS_JUMP; end
        S_I_ALU:       begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; w_alu_op = ALUOP_IMM; end
        S_I_WREG:      RegWrite = 1'b1;
        S_LUI:         begin RegWrite = 1'b1; MemtoReg = 2'b10; end
        S_JR:          begin PCWrite = 1'b1; PCSource = PCS_RS; end
        S_JAL:         begin RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b11; end
        S_JALR:        begin RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b11; end
        S_SRL:         begin ALUSrcA = 1'b1; Shift = 1'b1; w_alu_op = ALUOP_FUNC; end
        S_TRAP: begin
          EPCWrite = 1'b1; CauseWrite = 1'b1; PCWrite = 1'b1; PCSource = PCS_EXC;
        end
        default: ;
      endcase
    end
  end

  alu_op_decode u_alu_op_decode (
    .i_alu_op        (w_alu_op),
    .i_op            (w_op),
    .i_func          (w_func),
    .o_alu_operation (w_alu_operation)
  );

  assign ALU_operation = reset ? 3'b000 : w_alu_operation;
  assign cause         = reset ? CAUSE_NONE : r_cause;
  assign CPU_MIO       = MemRead | MemWrite;
  assign state_out     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b1;
  logic [31:0] Inst_in = 32'h0;

  logic MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond;
  logic Branch, Shift, EPCWrite, CauseWrite, CPU_MIO;
  logic [1:0] cause, RegDst, MemtoReg, ALUSrcB;
  logic [2:0] PCSource, ALU_operation;
  logic [4:0] state_out;

  logic n_MemRead, n_MemWrite, n_IorD, n_IRWrite, n_RegWrite, n_ALUSrcA, n_PCWrite, n_PCWriteCond;
  logic n_Branch, n_Shift, n_EPCWrite, n_CauseWrite, n_CPU_MIO;
  logic [1:0] n_cause, n_RegDst, n_MemtoReg, n_ALUSrcB;
  logic [2:0] n_PCSource, n_ALU_operation;
  logic [4:0] n_state_out;

  wire [26:0] out_a = {MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                       Branch, Shift, EPCWrite, CauseWrite, CPU_MIO, cause, RegDst, MemtoReg,
                       ALUSrcB, PCSource, ALU_operation};
  wire [26:0] out_n = {n_MemRead, n_MemWrite, n_IorD, n_IRWrite, n_RegWrite, n_ALUSrcA, n_PCWrite,
                       n_PCWriteCond, n_Branch, n_Shift, n_EPCWrite, n_CauseWrite, n_CPU_MIO,
                       n_cause, n_RegDst, n_MemtoReg, n_ALUSrcB, n_PCSource, n_ALU_operation};

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] I_ADD  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
  localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] I_ADDI = {6'b001000, 5'd1, 5'd2, 16'd5};
  localparam logic [31:0] I_ANDI = {6'b001100, 5'd1, 5'd2, 16'd5};
  localparam logic [31:0] I_BEQ  = {6'b000100, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] I_JAL  = {6'b000011, 26'd64};
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT(1'b1), .TRAP_EN(1'b1), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .Inst_in(Inst_in), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .Shift(Shift), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .cause(cause),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_operation(ALU_operation), .CPU_MIO(CPU_MIO), .state_out(state_out)
  );

  multicycle_ctrl #(.MEM_WAIT(1'b1), .TRAP_EN(1'b0), .TIMEOUT(4)) u_dut_nt (
    .clk(clk), .reset(reset), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .Inst_in(Inst_in), .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IorD(n_IorD),
    .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .PCWrite(n_PCWrite),
    .PCWriteCond(n_PCWriteCond), .Branch(n_Branch), .Shift(n_Shift), .EPCWrite(n_EPCWrite),
    .CauseWrite(n_CauseWrite), .cause(n_cause), .RegDst(n_RegDst), .MemtoReg(n_MemtoReg),
    .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource), .ALU_operation(n_ALU_operation),
    .CPU_MIO(n_CPU_MIO), .state_out(n_state_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; overflow = 1'b0; MIO_ready = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Inst_in = I_LW;
    step(); step(); step();
    MIO_ready = 1'b0; #1;
    n_cmp++; if (state_out !== 5'd3) begin n_bad++; $display("FAIL rst_pre_state got %0d want 3", state_out); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (out_a !== 27'd0) begin n_bad++; $display("FAIL rst_outs c%0d got %h want 0", i, out_a); end
      n_cmp++; if (out_n !== 27'd0) begin n_bad++; $display("FAIL rst_outs_nt c%0d got %h want 0", i, out_n); end
      step();
    end
    reset = 1'b0; MIO_ready = 1'b1; #1;
    n_cmp++; if (state_out !== 5'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state_out); end
    n_cmp++; if (MemRead !== 1'b1) begin n_bad++; $display("FAIL rst_memread got %b want 1", MemRead); end
    n_cmp++; if (IorD !== 1'b0) begin n_bad++; $display("FAIL rst_iord got %b want 0", IorD); end
    n_cmp++; if (CPU_MIO !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_mio got %b want 1", CPU_MIO); end
  endtask

  task automatic test_add();
    int   st[5] = '{0, 1, 6, 7, 0};
    logic rw[5] = '{0, 0, 0, 1, 0};
    do_reset();
    Inst_in = I_ADD;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state_out !== 5'(st[i])) begin n_bad++; $display("FAIL add_state c%0d got %0d want %0d", i, state_out, st[i]); end
      n_cmp++; if (RegWrite !== rw[i]) begin n_bad++; $display("FAIL add_regwrite c%0d got %b want %b", i, RegWrite, rw[i]); end
      if (i == 2) begin
        n_cmp++; if (ALU_operation !== 3'b010) begin n_bad++; $display("FAIL add_aluop got %b want 010", ALU_operation); end
      end
      if (i == 3) begin
        n_cmp++; if (RegDst !== 2'b01) begin n_bad++; $display("FAIL add_regdst got %b want 01", RegDst); end
      end
      step();
    end
  endtask

  task automatic test_lw_stall();
    logic rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int   st[8]  = '{0, 1, 2, 3, 3, 3, 3, 4};
    logic mr[8]  = '{1, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    Inst_in = I_LW;
    for (int i = 0; i < 8; i++) begin
      MIO_ready = rdy[i]; #1;
      n_cmp++; if (state_out !== 5'(st[i])) begin n_bad++; $display("FAIL lw_state c%0d got %0d want %0d", i, state_out, st[i]); end
      n_cmp++; if (MemRead !== mr[i]) begin n_bad++; $display("FAIL lw_memread c%0d got %b want %b", i, MemRead, mr[i]); end
      if (i == 0) begin
        n_cmp++; if ({PCWrite, IRWrite} !== 2'b11) begin n_bad++; $display("FAIL lw_fetch_we got %b want 11", {PCWrite, IRWrite}); end
      end
      if (i == 5) begin
        n_cmp++; if (IorD !== 1'b1) begin n_bad++; $display("FAIL lw_iord got %b want 1", IorD); end
      end
      if (i == 7) begin
        n_cmp++; if ({RegWrite, MemtoReg} !== 3'b101) begin n_bad++; $display("FAIL lw_wback got %b want 101", {RegWrite, MemtoReg}); end
      end
      step();
    end
    MIO_ready = 1'b1; #1;
    n_cmp++; if (state_out !== 5'd0) begin n_bad++; $display("FAIL lw_latency got %0d want 0", state_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    Inst_in = I_ADDI; overflow = 1'b1;
    step(); step(); #1;
    n_cmp++; if (state_out !== 5'd11 || RegWrite !== 1'b0) begin n_bad++; $display("FAIL ovf_ialu got %0d/%b want 11/0", state_out, RegWrite); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd18) begin n_bad++; $display("FAIL ovf_trap_state got %0d want 18", state_out); end
    n_cmp++; if (cause !== 2'b01) begin n_bad++; $display("FAIL ovf_cause got %b want 01", cause); end
    n_cmp++; if ({EPCWrite, CauseWrite, PCWrite, RegWrite} !== 4'b1110) begin n_bad++; $display("FAIL ovf_trap_we got %b want 1110", {EPCWrite, CauseWrite, PCWrite, RegWrite}); end
    n_cmp++; if (PCSource !== 3'b100) begin n_bad++; $display("FAIL ovf_pcsource got %b want 100", PCSource); end
    n_cmp++; if (n_state_out !== 5'd12 || n_RegWrite !== 1'b1) begin n_bad++; $display("FAIL ovf_nt_wreg got %0d/%b want 12/1", n_state_out, n_RegWrite); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd0 || cause !== 2'b00) begin n_bad++; $display("FAIL ovf_exit got %0d/%b want 0/00", state_out, cause); end
    n_cmp++; if (n_state_out !== 5'd0) begin n_bad++; $display("FAIL ovf_nt_exit got %0d want 0", n_state_out); end
    Inst_in = I_ANDI;
    step(); step(); #1;
    n_cmp++; if (ALU_operation !== 3'b000) begin n_bad++; $display("FAIL andi_aluop got %b want 000", ALU_operation); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd12 || RegWrite !== 1'b1) begin n_bad++; $display("FAIL andi_ovf_ignored got %0d/%b want 12/1", state_out, RegWrite); end
    overflow = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    Inst_in = I_BAD;
    step(); #1;
    n_cmp++; if (state_out !== 5'd1) begin n_bad++; $display("FAIL ill_decode got %0d want 1", state_out); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd18 || cause !== 2'b10) begin n_bad++; $display("FAIL ill_trap got %0d/%b want 18/10", state_out, cause); end
    n_cmp++; if (n_state_out !== 5'd0 || n_cause !== 2'b00) begin n_bad++; $display("FAIL ill_nt_fetch got %0d/%b want 0/00", n_state_out, n_cause); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd0 || cause !== 2'b00) begin n_bad++; $display("FAIL ill_exit got %0d/%b want 0/00", state_out, cause); end
  endtask

  task automatic test_timeout();
    do_reset();
    Inst_in = I_ADD;
    MIO_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (state_out !== 5'd0) begin n_bad++; $display("FAIL tmo_stall_state c%0d got %0d want 0", i, state_out); end
      n_cmp++; if ({MemRead, PCWrite, IRWrite} !== 3'b100) begin n_bad++; $display("FAIL tmo_stall_en c%0d got %b want 100", i, {MemRead, PCWrite, IRWrite}); end
      step();
    end
    #1;
    n_cmp++; if (state_out !== 5'd18 || cause !== 2'b11) begin n_bad++; $display("FAIL tmo_trap got %0d/%b want 18/11", state_out, cause); end
    n_cmp++; if (PCSource !== 3'b100) begin n_bad++; $display("FAIL tmo_pcsource got %b want 100", PCSource); end
    n_cmp++; if (n_state_out !== 5'd0 || n_PCWrite !== 1'b0) begin n_bad++; $display("FAIL tmo_nt_hold got %0d/%b want 0/0", n_state_out, n_PCWrite); end
    step(); #1;
    n_cmp++; if (state_out !== 5'd0 || cause !== 2'b00) begin n_bad++; $display("FAIL tmo_exit got %0d/%b want 0/00", state_out, cause); end
    MIO_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[8] = '{I_BEQ, I_BEQ, I_BEQ, I_JAL, I_JAL, I_JAL, I_JAL, I_JAL};
    int          st[8]  = '{0, 1, 8, 0, 1, 15, 9, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      Inst_in = ins[i]; #1;
      n_cmp++; if (state_out !== 5'(st[i])) begin n_bad++; $display("FAIL b2b_state c%0d got %0d want %0d", i, state_out, st[i]); end
      if (i == 2) begin
        n_cmp++; if ({Branch, PCWriteCond, PCSource, ALU_operation} !== 8'b11_001_110) begin
          n_bad++; $display("FAIL b2b_beq got %b want 11001110", {Branch, PCWriteCond, PCSource, ALU_operation}); end
      end
      if (i == 5) begin
        n_cmp++; if ({RegWrite, RegDst, MemtoReg} !== 5'b1_10_11) begin
          n_bad++; $display("FAIL b2b_jal got %b want 11011", {RegWrite, RegDst, MemtoReg}); end
      end
      if (i == 6) begin
        n_cmp++; if ({PCWrite, PCSource} !== 4'b1_010) begin
          n_bad++; $display("FAIL b2b_jump got %b want 1010", {PCWrite, PCSource}); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_overflow();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
